traffic_phase_scheduler: RTL
============================

// Module: traffic_phase_scheduler
// PURPOSE
//   Sequences a two-road intersection: NS/EW green, yellow and all-red clearance phases.
//   Serves latched pedestrian walk requests and an emergency preemption input.
//   Sits above the per-lamp drivers. Timing is counted in ticks from an internal prescaler.
// PARAMETERS
//   TICK_DIV    1000  clk cycles per tick (>=2)
//   NS_GREEN_T  30    NS green duration, ticks
//   EW_GREEN_T  20    EW green duration, ticks
//   YELLOW_T    5     yellow duration, ticks (both roads)
//   ALL_RED_T   2     all-red clearance, ticks
//   WALK_T      10    pedestrian walk, ticks
//   CNT_W       6     phase timer width; must hold max(*_T)
// PORTS
//   clk        in   1  clock
//   reset_n    in   1  asynchronous active-low reset
//   ped_req    in   1  pedestrian button, sampled every cycle, any-high latches
//   emerg_req  in   1  emergency preempt, level
//   emerg_dir  in   1  preempt direction: 0=NS, 1=EW
//   ns_green/ns_yellow/ns_red  out 1 each  NS lamps
//   ew_green/ew_yellow/ew_red  out 1 each  EW lamps
//   walk       out  1  pedestrian walk lamp
//   ped_ack    out  1  one-cycle pulse on PED_WALK entry
//   phase      out  3  current state code
// BEHAVIOUR
//   States and codes: ALL_RED=0, NS_GREEN=1, NS_YELLOW=2, EW_GREEN=3, EW_YELLOW=4, PED_WALK=5.
//   Outputs are a Moore decode of the registered state. Exactly one lamp per road is lit.
//   Red is lit in every non-green, non-yellow state for that road. walk=1 only in PED_WALK.
//   Reset: state=ALL_RED, next_dir=NS, ped_pend=0, timer=0, prescaler=0.
//   Reset outputs: ns_red=ew_red=1; all other outputs 0; phase=0.
//   Tick generation:
//     - The prescaler restarts at 0 on every state entry.
//     - tick fires when prescaler==TICK_DIV-1.
//     - A phase of D ticks therefore lasts exactly D*TICK_DIV cycles.
//   Phase timer:
//     - Cleared on state entry; incremented on tick.
//     - The phase ends on the tick where timer==D-1. The next state is registered on that edge.
//   Transitions:
//     - NS_GREEN -> NS_YELLOW.
//     - NS_YELLOW -> ALL_RED, and next_dir:=EW.
//     - EW_GREEN -> EW_YELLOW.
//     - EW_YELLOW -> ALL_RED, and next_dir:=NS.
//     - ALL_RED end, priority order: emerg_req -> green(emerg_dir); else ped_pend -> PED_WALK;
//       else green(next_dir).
//     - PED_WALK end -> green(next_dir). No second all-red.
//   Pedestrian:
//     - ped_req sets ped_pend. ped_pend is cleared on PED_WALK entry.
//     - A request during PED_WALK re-latches and is served at the following ALL_RED.
//     - If set and clear coincide on the entry edge, set wins.
//   Emergency, evaluated every cycle on the current emerg_req/emerg_dir:
//     - Green of the other road: go to that road's yellow on the next edge, not tick-aligned.
//     - Green of emerg_dir: the timer is held at 0. Normal duration counts from 0 after release.
//     - Yellow and ALL_RED: run to completion. ALL_RED then exits to green(emerg_dir).
//     - PED_WALK: abort to ALL_RED next edge, with ped_pend set again and next_dir kept.
//     - A change of emerg_dir mid-hold is treated as a fresh request.
//   Mid-operation reset_n low: returns immediately to reset values. No lamp glitch beyond the
//     async clear.
//   ped_ack is registered: high for exactly the first cycle of PED_WALK.
// STRUCTURE
//   Package traffic_pkg:
//     - phase_t enum and the state codes above.
//     - dir_t (NS=0, EW=1).
//   One sub-module: traffic_tick_gen.
//     - Parameter TICK_DIV; inputs clk, reset_n, restart.
//     - Output tick.
//   The scheduler holds the FSM, timer, next_dir, ped_pend and the output decode.
// TESTING (TICK_DIV=4, defaults otherwise; cycle n = n-th rising clk edge after reset_n rise)
//   1 Idle cycle -> NS_GREEN at 8, NS_YELLOW at 128, ALL_RED at 148, EW_GREEN at 156,
//     EW_YELLOW at 236, ALL_RED at 256, NS_GREEN at 264.
//   2 ped_req pulse at cycle 50 -> PED_WALK at 156 with ped_ack=1 for 1 cycle, walk=1,
//     both roads red; EW_GREEN at 196.
//   3 emerg_req=1, emerg_dir=EW at cycle 40, held -> NS_YELLOW at 41, ALL_RED at 61,
//     EW_GREEN at 69, held while asserted.
//     Release at 300 -> EW_YELLOW exactly 80 cycles after release.
//   4 emerg_req=1, dir=NS during PED_WALK -> ALL_RED next edge; after 8 cycles NS_GREEN;
//     after release the walk is served at the next ALL_RED.
//   5 reset_n low mid-EW_YELLOW -> all outputs at reset values asynchronously;
//     restart matches scenario 1 timing.
//   6 Every cycle, check lamp invariants: never both greens, never green+yellow on one road,
//     walk only with both reds.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the intersection phase scheduler.
package traffic_pkg;

   typedef enum logic [2:0] {
      ALL_RED   = 3'd0,
      NS_GREEN  = 3'd1,
      NS_YELLOW = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      PED_WALK  = 3'd5
   } phase_t;

   typedef enum logic {
      NS = 1'b0,
      EW = 1'b1
   } dir_t;

   function automatic phase_t green_of(input dir_t d);
      phase_t p;
      if (d == EW) p = EW_GREEN;
      else         p = NS_GREEN;
      return p;
   endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// Free-running tick prescaler; restart forces the count back to zero so every
// phase starts on a whole tick boundary.
module traffic_tick_gen #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   output logic tick
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_q, pre_d;

   assign tick = (pre_q == PRE_LAST);

   always_comb begin
      pre_d = pre_q + 1'b1;
      if (restart || tick) pre_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pre_q <= '0;
      else          pre_q <= pre_d;
   end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection sequencer with latched pedestrian walk and emergency preemption.
//   state     | meaning
//   ALL_RED   | clearance, both roads red; picks the next green or walk
//   NS_GREEN  | NS road green
//   NS_YELLOW | NS road yellow
//   EW_GREEN  | EW road green
//   EW_YELLOW | EW road yellow
//   PED_WALK  | both roads red, walk lamp lit
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int TICK_DIV   = 1000,
   parameter int NS_GREEN_T = 30,
   parameter int EW_GREEN_T = 20,
   parameter int YELLOW_T   = 5,
   parameter int ALL_RED_T  = 2,
   parameter int WALK_T     = 10,
   parameter int CNT_W      = 6
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ped_req,
   input  logic       emerg_req,
   input  logic       emerg_dir,
   output logic       ns_green,
   output logic       ns_yellow,
   output logic       ns_red,
   output logic       ew_green,
   output logic       ew_yellow,
   output logic       ew_red,
   output logic       walk,
   output logic       ped_ack,
   output logic [2:0] phase
);

   phase_t             state_q, state_d;
   dir_t               next_dir_q, next_dir_d;
   dir_t               e_dir;
   logic               ped_pend_q, ped_pend_d;
   logic               ped_ack_q, ped_ack_d;
   logic [CNT_W-1:0]   timer_q, timer_d;
   logic [CNT_W-1:0]   dur_m1;
   logic               tick, restart, hold, phase_end;

   assign e_dir = dir_t'(emerg_dir);

   traffic_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .restart (restart),
      .tick    (tick)
   );

   always_comb begin
      case (state_q)
         NS_GREEN:  dur_m1 = CNT_W'(NS_GREEN_T - 1);
         EW_GREEN:  dur_m1 = CNT_W'(EW_GREEN_T - 1);
         NS_YELLOW: dur_m1 = CNT_W'(YELLOW_T - 1);
         EW_YELLOW: dur_m1 = CNT_W'(YELLOW_T - 1);
         PED_WALK:  dur_m1 = CNT_W'(WALK_T - 1);
         default:   dur_m1 = CNT_W'(ALL_RED_T - 1);
      endcase
   end

   assign phase_end = tick && (timer_q == dur_m1);

   always_comb begin
      state_d    = state_q;
      next_dir_d = next_dir_q;
      ped_pend_d = ped_pend_q | ped_req;
      hold       = 1'b0;
      case (state_q)
         ALL_RED: begin
            if (phase_end) begin
               if (emerg_req)       state_d = green_of(e_dir);
               else if (ped_pend_q) state_d = PED_WALK;
               else                 state_d = green_of(next_dir_q);
            end
         end
         NS_GREEN: begin
            if (emerg_req && e_dir == EW) state_d = NS_YELLOW;
            else if (emerg_req)           hold    = 1'b1;
            else if (phase_end)           state_d = NS_YELLOW;
         end
         NS_YELLOW: begin
            if (phase_end) begin
               state_d    = ALL_RED;
               next_dir_d = EW;
            end
         end
         EW_GREEN: begin
            if (emerg_req && e_dir == NS) state_d = EW_YELLOW;
            else if (emerg_req)           hold    = 1'b1;
            else if (phase_end)           state_d = EW_YELLOW;
         end
         EW_YELLOW: begin
            if (phase_end) begin
               state_d    = ALL_RED;
               next_dir_d = NS;
            end
         end
         PED_WALK: begin
            // aborted walk is owed again at the next clearance
            if (emerg_req) begin
               state_d    = ALL_RED;
               ped_pend_d = 1'b1;
            end else if (phase_end) begin
               state_d = green_of(next_dir_q);
            end
         end
         default: state_d = ALL_RED;
      endcase

      ped_ack_d = (state_d == PED_WALK) && (state_q != PED_WALK);
      if (ped_ack_d) ped_pend_d = ped_req;

      restart = (state_d != state_q) || hold;
      if (restart)   timer_d = '0;
      else if (tick) timer_d = timer_q + 1'b1;
      else           timer_d = timer_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ALL_RED;
         next_dir_q <= NS;
         ped_pend_q <= 1'b0;
         ped_ack_q  <= 1'b0;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         next_dir_q <= next_dir_d;
         ped_pend_q <= ped_pend_d;
         ped_ack_q  <= ped_ack_d;
         timer_q    <= timer_d;
      end
   end

   always_comb begin
      ns_green  = (state_q == NS_GREEN);
      ns_yellow = (state_q == NS_YELLOW);
      ns_red    = (state_q != NS_GREEN) && (state_q != NS_YELLOW);
      ew_green  = (state_q == EW_GREEN);
      ew_yellow = (state_q == EW_YELLOW);
      ew_red    = (state_q != EW_GREEN) && (state_q != EW_YELLOW);
      walk      = (state_q == PED_WALK);
   end

   assign ped_ack = ped_ack_q;
   assign phase   = state_q;

endmodule
